// File: rtl/baud_gen.sv
// Baud-rate tick generator: fractional-divisor oversample tick plus bit and
// mid-bit ticks derived from a sample counter, with a double-buffered divisor.
module baud_gen #(
  parameter int unsigned CLOCK       = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FRAC_W      = 4,
  parameter logic [DIV_W+FRAC_W-1:0] DEFAULT_DIV = (DIV_W+FRAC_W)'(
    (64'(CLOCK) * (64'(1) << FRAC_W) * 64'd2 + 64'(BAUD_RATE) * 64'(OVERSAMPLE))
    / (64'(BAUD_RATE) * 64'(OVERSAMPLE) * 64'd2))
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic [DIV_W+FRAC_W-1:0] div_i,
  input  logic                    div_load_i,
  output logic                    tick_o,
  output logic                    bit_tick_o,
  output logic                    mid_tick_o,
  output logic                    div_pending_o
);

  localparam int unsigned DW = DIV_W + FRAC_W;
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_MID  = (OVERSAMPLE < 2) ? 4'd0 : 4'(OVERSAMPLE / 2 - 1);

  logic [DW-1:0]     div_act;
  logic [DW-1:0]     div_pend;
  logic              pend;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [3:0]        scnt;

  logic [DIV_W-1:0]  div_int;
  logic [DIV_W-1:0]  int_c;
  logic [FRAC_W-1:0] div_frac;
  logic [FRAC_W:0]   acc_sum;
  logic              ext;
  logic [DIV_W-1:0]  period_m1;
  logic              at_end;
  logic              tick;
  logic              xfer;

  // ext is derived from acc and div_act, both of which only change at a period
  // boundary while counting, so it equals the value captured at period start.
  // The >= compare keeps the counter bounded if the divisor shrinks while disabled.
  always_comb begin
    div_int   = div_act[DW-1:FRAC_W];
    div_frac  = div_act[FRAC_W-1:0];
    int_c     = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    acc_sum   = {1'b0, acc} + {1'b0, div_frac};
    ext       = acc_sum[FRAC_W];
    period_m1 = int_c - DIV_W'(1) + DIV_W'(ext);
    at_end    = (cnt >= period_m1);
    tick      = en_i & ~clear_i & ~rst_i & at_end;
    xfer      = pend & (tick | ~en_i | clear_i);
  end

  assign tick_o        = tick;
  assign bit_tick_o    = tick & (scnt == S_LAST);
  assign mid_tick_o    = tick & (scnt == S_MID);
  assign div_pending_o = pend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_act  <= DEFAULT_DIV;
      div_pend <= '0;
      pend     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      scnt     <= '0;
    end else begin
      if (xfer) div_act <= div_pend;
      // A load coinciding with a transfer stays pending for the next boundary.
      if (div_load_i) begin
        div_pend <= div_i;
        pend     <= 1'b1;
      end else if (xfer) begin
        pend <= 1'b0;
      end

      if (clear_i) begin
        cnt  <= '0;
        acc  <= '0;
        scnt <= '0;
      end else if (en_i) begin
        if (tick) begin
          cnt  <= '0;
          acc  <= acc_sum[FRAC_W-1:0];
          scnt <= (scnt == S_LAST) ? 4'd0 : scnt + 4'd1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: tick timestamps are logged per cycle and
// compared against hand-computed cycle positions.
module tb_baud_gen;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned FRAC_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    clear;
  logic                    div_load;
  logic [DIV_W+FRAC_W-1:0] div;
  logic                    tick;
  logic                    bit_t;
  logic                    mid_t;
  logic                    pending;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int tick_q[$];
  int bit_q[$];
  int mid_q[$];
  int exp_q[$];
  int s;
  int n;
  int r;
  int e;

  baud_gen #(
    .CLOCK(100_000_000),
    .BAUD_RATE(115200),
    .OVERSAMPLE(16),
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .clear_i(clear),
    .div_i(div),
    .div_load_i(div_load),
    .tick_o(tick),
    .bit_tick_o(bit_t),
    .mid_tick_o(mid_t),
    .div_pending_o(pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick)  tick_q.push_back(cyc);
    if (bit_t) bit_q.push_back(cyc);
    if (mid_t) mid_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int want[$]);
    chk({tag, ".count"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < got.size() && i < want.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(want[i]));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k);
    repeat (k) nxt();
  endtask

  task automatic flush();
    tick_q.delete();
    bit_q.delete();
    mid_q.delete();
    exp_q.delete();
  endtask

  task automatic load_idle(input logic [DIV_W+FRAC_W-1:0] v);
    en       = 1'b0;
    div      = v;
    div_load = 1'b1;
    nxt();
    div_load = 1'b0;
    run(2);
  endtask

  task automatic restart(output int start);
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    en    = 1'b1;
    flush();
    start = cyc;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; div_load = 1'b0; div = '0;
    run(3);
    rst = 1'b0;
    chk("reset.tick", 64'(tick), 64'd0);
    chk("reset.bit", 64'(bit_t), 64'd0);
    chk("reset.mid", 64'(mid_t), 64'd0);
    chk("reset.pending", 64'(pending), 64'd0);

    // int=5 frac=0 loaded while disabled, then free run
    div = {16'd5, 4'd0}; div_load = 1'b1;
    nxt();
    div_load = 1'b0;
    chk("load.pending_set", 64'(pending), 64'd1);
    nxt();
    chk("load.pending_clr", 64'(pending), 64'd0);
    chk("idle.no_ticks", 64'(tick_q.size()), 64'd0);
    en = 1'b1; flush(); s = cyc;
    run(170);
    for (int k = 0; k < 34; k++) exp_q.push_back(s + 4 + 5 * k);
    chk_q("basic.tick", tick_q, exp_q);
    exp_q.delete(); exp_q.push_back(s + 79); exp_q.push_back(s + 159);
    chk_q("basic.bit", bit_q, exp_q);
    exp_q.delete(); exp_q.push_back(s + 39); exp_q.push_back(s + 119);
    chk_q("basic.mid", mid_q, exp_q);

    // enable dropped for 7 cycles with cnt=2
    restart(s);
    run(7);
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(8);
    exp_q.push_back(s + 4); exp_q.push_back(s + 16); exp_q.push_back(s + 21);
    chk_q("endrop.tick", tick_q, exp_q);

    // clear at cnt=3, scnt=7
    restart(s);
    run(38);
    clear = 1'b1; n = cyc;
    nxt();
    clear = 1'b0;
    run(87);
    for (int k = 0; k < 7; k++) exp_q.push_back(s + 4 + 5 * k);
    for (int k = 0; k < 17; k++) exp_q.push_back(n + 5 + 5 * k);
    chk_q("clear.tick", tick_q, exp_q);
    exp_q.delete(); exp_q.push_back(n + 80);
    chk_q("clear.bit", bit_q, exp_q);
    exp_q.delete(); exp_q.push_back(n + 40);
    chk_q("clear.mid", mid_q, exp_q);

    // int=5 frac=8: intervals 5,6,5,6,...
    load_idle({16'd5, 4'd8});
    restart(s);
    run(90);
    e = s - 1;
    for (int k = 0; k < 16; k++) begin
      e += (k % 2 == 0) ? 5 : 6;
      exp_q.push_back(e);
    end
    chk_q("frac.tick", tick_q, exp_q);
    exp_q.delete(); exp_q.push_back(s + 87);
    chk_q("frac.bit", bit_q, exp_q);
    exp_q.delete(); exp_q.push_back(s + 43);
    chk_q("frac.mid", mid_q, exp_q);

    // load int=10 mid-period while running at int=5
    load_idle({16'd5, 4'd0});
    restart(s);
    run(6);
    div = {16'd10, 4'd0}; div_load = 1'b1;
    nxt();
    div_load = 1'b0;
    chk("midload.pending_after_load", 64'(pending), 64'd1);
    run(2);
    chk("midload.pending_at_tick", 64'(pending), 64'd1);
    nxt();
    chk("midload.pending_after_xfer", 64'(pending), 64'd0);
    run(20);
    exp_q.push_back(s + 4); exp_q.push_back(s + 9);
    exp_q.push_back(s + 19); exp_q.push_back(s + 29);
    chk_q("midload.tick", tick_q, exp_q);

    // int=1 clamps to a 2-cycle period
    load_idle({16'd1, 4'd0});
    restart(s);
    run(10);
    for (int k = 0; k < 5; k++) exp_q.push_back(s + 1 + 2 * k);
    chk_q("clamp.tick", tick_q, exp_q);

    // reset on the would-be tick cycle, with a load pending
    load_idle({16'd7, 4'd0});
    restart(s);
    run(2);
    div = {16'd9, 4'd0}; div_load = 1'b1;
    nxt();
    div_load = 1'b0;
    chk("rst.pending_before", 64'(pending), 64'd1);
    run(3);
    rst = 1'b1;
    #1;
    chk("rst.tick_gated", 64'(tick), 64'd0);
    chk("rst.bit_gated", 64'(bit_t), 64'd0);
    chk("rst.mid_gated", 64'(mid_t), 64'd0);
    nxt();
    rst = 1'b0; r = cyc;
    chk("rst.pending_discarded", 64'(pending), 64'd0);
    chk("rst.no_tick", 64'(tick_q.size()), 64'd0);
    flush();
    run(220);
    // default divisor 868 = 54 + 4/16: periods 54,54,54,55
    exp_q.push_back(r + 53); exp_q.push_back(r + 107);
    exp_q.push_back(r + 161); exp_q.push_back(r + 216);
    chk_q("rst.default_tick", tick_q, exp_q);
    chk("rst.pending_end", 64'(pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
